// File: rtl/pc_pkg.sv
// Shared definitions for the fetch-stage PC unit: redirect selector encodings
// and default reset/exception addresses.
package pc_pkg;

  typedef enum logic [1:0] {
    SEL_SEQ = 2'd0,
    SEL_BR  = 2'd1,
    SEL_JR  = 2'd2,
    SEL_J   = 2'd3
  } redir_sel_e;

  localparam logic [31:0] DEF_RESET_PC  = 32'h0000_3000;
  localparam logic [31:0] DEF_EXC_PC    = 32'h0000_4180;
  localparam logic [31:0] DEF_IMEM_BASE = 32'h0000_3000;
  localparam logic [31:0] DEF_IMEM_SIZE = 32'h0000_4000;

endpackage

// File: rtl/npc_target_calc.sv
// Combinational control-transfer target for the instruction resolved in D.
// All arithmetic wraps modulo 2^XLEN.
module npc_target_calc
  import pc_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [1:0]      redir_sel,
  input  logic [XLEN-1:0] base_pc,
  input  logic [XLEN-1:0] imm32,
  input  logic [XLEN-1:0] reg_ra,
  input  logic [25:0]     imm26,
  output logic [XLEN-1:0] target
);

  redir_sel_e      sel;
  logic [XLEN-1:0] seq_pc;

  assign sel    = redir_sel_e'(redir_sel);
  assign seq_pc = base_pc + XLEN'(4);

  always_comb begin
    target = seq_pc;
    unique case (sel)
      SEL_SEQ: target = seq_pc;
      // Dropping the top two offset bits is the word-to-byte shift; sign is preserved modulo 2^XLEN.
      SEL_BR:  target = seq_pc + {imm32[XLEN-3:0], 2'b00};
      SEL_JR:  target = reg_ra;
      SEL_J:   target = {seq_pc[XLEN-1:28], imm26, 2'b00};
      default: target = seq_pc;
    endcase
  end

endmodule

// File: rtl/pc_unit.sv
// Fetch-stage PC register with stall hold, a one-entry buffer for redirects
// arriving during a stall, and exception/ERET redirection.
module pc_unit
  import pc_pkg::*;
#(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = XLEN'(DEF_RESET_PC),
  parameter logic [XLEN-1:0] EXC_PC    = XLEN'(DEF_EXC_PC),
  parameter logic [XLEN-1:0] IMEM_BASE = XLEN'(DEF_IMEM_BASE),
  parameter logic [XLEN-1:0] IMEM_SIZE = XLEN'(DEF_IMEM_SIZE)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            redir_valid,
  input  logic [1:0]      redir_sel,
  input  logic [XLEN-1:0] base_pc,
  input  logic [XLEN-1:0] imm32,
  input  logic [XLEN-1:0] reg_ra,
  input  logic [25:0]     imm26,
  input  logic            exc_req,
  input  logic            eret_req,
  input  logic [XLEN-1:0] epc,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] npc,
  output logic            redir_pend,
  output logic            adel_f
);

  logic [XLEN-1:0] target;
  logic [XLEN-1:0] pend_target;
  logic [XLEN-1:0] pc_off;
  logic            pend_valid;
  logic            redir_take;
  logic            trap;

  npc_target_calc #(.XLEN(XLEN)) u_target (
    .redir_sel (redir_sel),
    .base_pc   (base_pc),
    .imm32     (imm32),
    .reg_ra    (reg_ra),
    .imm26     (imm26),
    .target    (target)
  );

  assign redir_take = redir_valid && (redir_sel_e'(redir_sel) != SEL_SEQ);
  assign trap       = exc_req || eret_req;

  // NOTE: every branch assigns npc after a default, so no latch is inferred.
  always_comb begin
    npc = pc + XLEN'(4);
    if (exc_req)         npc = EXC_PC;
    else if (eret_req)   npc = epc;
    else if (redir_take) npc = target;
    else if (pend_valid) npc = pend_target;
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc          <= RESET_PC;
      pend_valid  <= 1'b0;
      pend_target <= '0;
    end else begin
      if (trap || !stall) pc <= npc;
      if (trap || !stall) begin
        pend_valid <= 1'b0;
      end else if (redir_take) begin
        pend_valid  <= 1'b1;
        pend_target <= target;
      end
    end
  end

  assign redir_pend = pend_valid;

  // Unsigned offset from the window base: addresses below the base wrap to a large value.
  assign pc_off = pc - IMEM_BASE;
  assign adel_f = (pc[1:0] != 2'b00) || (pc_off >= IMEM_SIZE);

endmodule
